// File: rtl/debounce_bank_if.sv
// Button-pin and debounced-event bundle for debounce_bank.
// The slave side is the debouncer; the master side is whoever drives the pins and consumes the events.
interface debounce_bank_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  logic             any_pressed;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed
  );
endinterface

// File: rtl/debounce_bank.sv
// N-channel push-button debouncer with press/release/long-press/auto-repeat pulses.
//   state         | meaning
//   ST_RELEASED   | button not accepted as pressed
//   ST_HELD       | accepted press, counting towards long press
//   ST_LONG_HELD  | long press reached, counting repeat periods
module debounce_bank #(
  parameter int N_BTN         = 4,
  parameter int DELAY         = 500_000,
  parameter int LONG_DELAY    = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_bank_if.slave bus
);

  localparam int MAX_A = (DELAY > LONG_DELAY) ? DELAY : LONG_DELAY;
  localparam int MAX_V = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] DLY_M1 = CW'(DELAY - 1);
  localparam logic [CW-1:0] LNG_M1 = CW'(LONG_DELAY - 1);
  localparam logic [CW-1:0] REP_M1 = CW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
  localparam logic [N_BTN-1:0] REL_LVL = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_HELD,
    ST_LONG_HELD
  } hold_st_e;

  logic [N_BTN-1:0] sync0_q, sync0_d;
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] level_prev_q, level_prev_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             any_q, any_d;
  logic [N_BTN-1:0] level, level_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [CW-1:0]    hold_cnt_q [N_BTN];
  logic [CW-1:0]    hold_cnt_d [N_BTN];
  hold_st_e         state_q [N_BTN];
  hold_st_e         state_d [N_BTN];

  // Normalised so that 1 always means pressed.
  assign level = stable_q ^ REL_LVL;

  always_comb begin
    sync0_d      = bus.btn_in;
    sync1_d      = sync0_q;
    stable_d     = stable_q;
    level_prev_d = level;
    press_d      = level & ~level_prev_q;
    release_d    = ~level & level_prev_q;
    long_d       = '0;
    repeat_d     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i]      = '0;
      hold_cnt_d[i] = hold_cnt_q[i];
      state_d[i]    = state_q[i];

      if (sync1_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DLY_M1) begin
          stable_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end

      // A release on the same edge as a long/repeat terminal count wins.
      case (state_q[i])
        ST_RELEASED: begin
          hold_cnt_d[i] = '0;
          if (press_d[i]) begin
            state_d[i] = ST_HELD;
          end
        end
        ST_HELD: begin
          if (release_d[i]) begin
            state_d[i]    = ST_RELEASED;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == LNG_M1) begin
            long_d[i]     = 1'b1;
            state_d[i]    = ST_LONG_HELD;
            hold_cnt_d[i] = '0;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
          end
        end
        ST_LONG_HELD: begin
          if (release_d[i]) begin
            state_d[i]    = ST_RELEASED;
            hold_cnt_d[i] = '0;
          end else if (REPEAT_PERIOD == 0) begin
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == REP_M1) begin
            repeat_d[i]   = 1'b1;
            hold_cnt_d[i] = '0;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i]    = ST_RELEASED;
          hold_cnt_d[i] = '0;
        end
      endcase
    end
    level_d = stable_d ^ REL_LVL;
    any_d   = |level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q      <= REL_LVL;
      sync1_q      <= REL_LVL;
      stable_q     <= REL_LVL;
      level_prev_q <= '0;
      press_q      <= '0;
      release_q    <= '0;
      long_q       <= '0;
      repeat_q     <= '0;
      any_q        <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]      <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= ST_RELEASED;
      end
    end else begin
      sync0_q      <= sync0_d;
      sync1_q      <= sync1_d;
      stable_q     <= stable_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      repeat_q     <= repeat_d;
      any_q        <= any_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]      <= cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign bus.btn_level     = level;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.any_pressed   = any_q;

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces N_BTN asynchronous push-buttons in parallel and gives per-channel outputs:
  - debounced level
  - press and release pulses
  - long-press pulse
  - optional auto-repeat pulses while held
- Sits between board button pins and the image-select / mode control logic of the LED panel.

Parameters:
- N_BTN, 4: number of independent button channels.
- DELAY, 500_000: consecutive cycles a new input level must persist before it is accepted (~20 ms); must be ≥1.
- LONG_DELAY, 12_500_000: cycles held after an accepted press before long_pulse fires; must be ≥1.
- REPEAT_PERIOD, 2_500_000: cycles between repeat_pulse while long-held; 0 disables auto-repeat.
- ACTIVE_LOW, 1: 1 = button pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_BTN  raw, asynchronous button pins.
- btn_level  out  N_BTN  debounced state; 1 = pressed, regardless of ACTIVE_LOW.
- press_pulse  out  N_BTN  one-cycle pulse on an accepted press.
- release_pulse  out  N_BTN  one-cycle pulse on an accepted release.
- long_pulse  out  N_BTN  one-cycle pulse when the hold reaches LONG_DELAY.
- repeat_pulse  out  N_BTN  one-cycle pulses every REPEAT_PERIOD after long_pulse.
- any_pressed  out  1  OR of btn_level.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0.
  - all counters 0.
  - sync flops and stable state at the released pin level (ACTIVE_LOW ? 1 : 0).
  - channel FSMs in RELEASED.
  - Reset mid-hold or mid-count discards everything; no pulse is emitted on reset entry or exit.
- Per-channel datapath; channels are fully independent:
  - 2-FF synchroniser: sync0 <= btn_in[i], sync1 <= sync0.
- Debounce counter (width = $clog2(max(DELAY, LONG_DELAY, REPEAT_PERIOD)+1)):
  - Each edge where sync1 != stable: cnt increments.
  - When cnt == DELAY-1 and they still differ: stable <= sync1, cnt <= 0.
  - Any edge where sync1 == stable: cnt <= 0. Glitches shorter than DELAY cycles are ignored.
- Latency: a pin change first sampled at edge E0 changes btn_level at edge E0+DELAY+1. The corresponding press/release pulse is high for exactly the cycle after that edge, registered at E0+DELAY+2.
- btn_level is the normalised stable state; pulses come from registered edge detection of btn_level.
- Hold FSM states: RELEASED, HELD, LONG_HELD.
  - RELEASED → HELD: on accepted press; hold_cnt <= 0.
  - HELD: hold_cnt increments each cycle. When hold_cnt == LONG_DELAY-1: assert long_pulse for one cycle, go to LONG_HELD, hold_cnt <= 0.
  - LONG_HELD, REPEAT_PERIOD != 0: hold_cnt increments. When hold_cnt == REPEAT_PERIOD-1: assert repeat_pulse for one cycle, hold_cnt <= 0.
  - LONG_HELD, REPEAT_PERIOD == 0: hold_cnt stays 0 and repeat_pulse is never asserted.
  - HELD or LONG_HELD → RELEASED: on accepted release; hold_cnt <= 0.
- Simultaneous events: if an accepted release coincides with the cycle long_pulse or repeat_pulse would fire, release wins and that pulse is suppressed.
- Pulse exclusivity: press_pulse and release_pulse never assert on the same channel in the same cycle. Minimum spacing between a channel's press and release pulses is DELAY cycles.
- any_pressed is registered, same cycle timing as btn_level.

Test Plan:
- Reset value: DELAY=4, ACTIVE_LOW=1, btn_in held 1, pulse rst_n → all outputs 0, any_pressed 0.
- Clean press: drive btn_in[0] to 0 at sampling edge E0.
  - btn_level[0] = 1 at E0+5.
  - press_pulse[0] high exactly one cycle at E0+6.
  - Other channels stay 0.
- Glitch rejection: drive btn_in[1] to 0 for 3 cycles, then 1 → no level change, no pulse. Repeat with 4 cycles → press accepted.
- Long press and repeat: LONG_DELAY=10, REPEAT_PERIOD=3, hold btn_in[2] low.
  - long_pulse once, 10 cycles after press_pulse.
  - repeat_pulse every 3 cycles thereafter.
  - On release: release_pulse once, and no further repeats.
- REPEAT_PERIOD=0: hold 50 cycles → one long_pulse, zero repeat_pulse.
- Concurrent channels and reset mid-operation:
  - Press channels 0 and 3 two cycles apart → independent pulses, any_pressed high while either is held.
  - Assert rst_n low mid-hold → outputs 0 immediately; no release_pulse after rst_n deasserts while pins stay released.
